// File: rtl/draw_layer_sequencer.sv
// Frame-paced layer sequencer: on each frame tick enables the pending layers one at
// a time (lowest index first) and forwards the active layer's pixels to the VGA port.
module draw_layer_sequencer #(
  parameter int                 NUM_LAYERS = 4,
  parameter int                 X_W        = 9,
  parameter int                 Y_W        = 8,
  parameter int                 COLOR_W    = 12,
  parameter int                 FRAME_DIV  = 833333,
  parameter logic [COLOR_W-1:0] KEY_COLOR  = '0,
  parameter logic [7:0]         KEY_EN     = 8'b0000_1110
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          go,
  input  logic [NUM_LAYERS-1:0]         layer_mask,
  input  logic [NUM_LAYERS*X_W-1:0]     layer_x,
  input  logic [NUM_LAYERS*Y_W-1:0]     layer_y,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]         layer_we,
  input  logic [NUM_LAYERS-1:0]         layer_done,
  output logic [NUM_LAYERS-1:0]         layer_enable,
  output logic [X_W-1:0]                X_out,
  output logic [Y_W-1:0]                Y_out,
  output logic [COLOR_W-1:0]            Color_out,
  output logic                          writeEn,
  output logic                          frame_tick,
  output logic                          frame_done,
  output logic                          busy,
  output logic [7:0]                    overrun_count
);

  localparam int                CUR_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int                DIV_W      = $clog2(FRAME_DIV);
  localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, SELECT, DRAW, FRAME_DONE} state_t;

  state_t                  state, state_next;
  logic [NUM_LAYERS-1:0]   pending, pending_next;
  logic [CUR_W-1:0]        cur, cur_next;
  logic [CUR_W-1:0]        lowest;
  logic [DIV_W-1:0]        tick_count;
  logic [X_W-1:0]          act_x;
  logic [Y_W-1:0]          act_y;
  logic [COLOR_W-1:0]      act_color;
  logic                    keyed;

  // Free-running divider; keeps pacing even while go is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                tick_count <= DIV_RELOAD;
    else if (tick_count == '0)  tick_count <= DIV_RELOAD;
    else                        tick_count <= tick_count - 1'b1;
  end

  assign frame_tick = (tick_count == '0);

  // Scanning down lets the lowest set bit win.
  always_comb begin
    lowest = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (pending[i]) lowest = CUR_W'(i);
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    cur_next     = cur;
    unique case (state)
      IDLE: begin
        if (go && frame_tick) begin
          pending_next = layer_mask;
          state_next   = SELECT;
        end
      end
      SELECT: begin
        if (pending == '0) begin
          state_next = FRAME_DONE;
        end else begin
          cur_next   = lowest;
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (layer_done[cur]) begin
          pending_next[cur] = 1'b0;
          state_next        = SELECT;
        end
      end
      FRAME_DONE: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      pending <= '0;
      cur     <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      cur     <= cur_next;
    end
  end

  assign layer_enable = (state == DRAW) ? (NUM_LAYERS'(1) << cur) : '0;
  assign busy         = (state != IDLE);
  assign frame_done   = (state == FRAME_DONE);

  assign act_x     = layer_x[cur*X_W +: X_W];
  assign act_y     = layer_y[cur*Y_W +: Y_W];
  assign act_color = layer_color[cur*COLOR_W +: COLOR_W];
  // Transparency is judged on the incoming colour, before it is registered.
  assign keyed     = KEY_EN[cur] && (act_color == KEY_COLOR);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      X_out     <= '0;
      Y_out     <= '0;
      Color_out <= '0;
      writeEn   <= 1'b0;
    end else if (state == DRAW) begin
      X_out     <= act_x;
      Y_out     <= act_y;
      Color_out <= act_color;
      writeEn   <= layer_we[cur] & ~keyed;
    end else begin
      writeEn   <= 1'b0;
    end
  end

  // A tick arriving while a frame is still in flight is dropped and counted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      overrun_count <= '0;
    else if (frame_tick && (state != IDLE) && (overrun_count != 8'hFF))
      overrun_count <= overrun_count + 8'd1;
  end

endmodule
